// File: rtl/counter4_pkg.sv
// counter4_pkg: shared constants, types and the next-count helper for counter4.
//   COUNTER4_DEFAULT_WIDTH : default counter width in bits
//   count_t                : default-width count value
//   next_count()           : enable-gated increment with wrap at a terminal value
package counter4_pkg;

    localparam int COUNTER4_DEFAULT_WIDTH = 4;

    typedef logic [COUNTER4_DEFAULT_WIDTH-1:0] count_t;

    // Works on 32-bit values so any legal WIDTH (1..32) can use it.
    // Any value at or above max_val loads 0, so a forced out-of-range
    // count recovers on the next enabled edge.
    function automatic logic [31:0] next_count(input logic [31:0] cur,
                                               input logic [31:0] max_val,
                                               input logic        en);
        if (!en) begin
            return cur;
        end
        if (cur >= max_val) begin
            return '0;
        end
        return cur + 32'd1;
    endfunction

endpackage

// File: rtl/counter4_if.sv
// counter4_if: groups the counter's enable and outputs.
//   en        : count enable (driven by the master)
//   count_out : registered count value (driven by the counter)
//   tc_out    : terminal-count flag, present only when COUNTER4_TC_EN is defined
// Modports: master = user of the counter, slave = counter4 itself.
// Signal semantics: en is sampled on the rising clock; there is no
// valid/ready handshake, the count is always valid after reset.
interface counter4_if
    import counter4_pkg::*;
#(
    parameter int WIDTH = COUNTER4_DEFAULT_WIDTH
) ();

    logic             en;
    logic [WIDTH-1:0] count_out;
`ifdef COUNTER4_TC_EN
    logic             tc_out;

    modport master (output en, input  count_out, input  tc_out);
    modport slave  (input  en, output count_out, output tc_out);
`else
    modport master (output en, input  count_out);
    modport slave  (input  en, output count_out);
`endif

endinterface

// File: rtl/counter4.sv
// counter4: free-running, enable-gated up-counter wrapping at MAX_VAL.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears the count
//   bus   : counter4_if.slave (en in; count_out out; tc_out out when enabled)
// Parameters:
//   WIDTH   : counter width, 1..32
//   MAX_VAL : terminal value, 0 < MAX_VAL <= 2**WIDTH-1
// Optional feature macro: COUNTER4_TC_EN adds tc_out = (count == MAX_VAL) && en.
module counter4
    import counter4_pkg::*;
#(
    parameter int          WIDTH   = COUNTER4_DEFAULT_WIDTH,
    parameter logic [31:0] MAX_VAL = 32'((64'd1 << WIDTH) - 64'd1)
) (
    input  logic      clk,
    input  logic      rst_n,
    counter4_if.slave bus
);

    localparam logic [63:0]      LP_LIMIT = (64'd1 << WIDTH) - 64'd1;
    localparam logic [WIDTH-1:0] LP_MAX   = MAX_VAL[WIDTH-1:0];

    // Reject illegal configurations at elaboration.
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("counter4: WIDTH must be in 1..32");
    end
    if (MAX_VAL == 32'd0 || {32'd0, MAX_VAL} > LP_LIMIT) begin : g_bad_max
        $error("counter4: MAX_VAL must satisfy 0 < MAX_VAL <= 2**WIDTH-1");
    end

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_next;

    assign w_next = WIDTH'(next_count(32'(r_count), MAX_VAL, bus.en));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else begin
            r_count <= w_next;
        end
    end

    assign bus.count_out = r_count;

`ifdef COUNTER4_TC_EN
    // High in the cycle before a wrap; the count is 0 during reset and
    // MAX_VAL is never 0, so this stays low while reset is held.
    assign bus.tc_out = (r_count == LP_MAX) && bus.en;
`endif

endmodule

// File: tb/tb_counter4.sv
// tb_counter4: self-checking bench for counter4 (default 4-bit instance and a
// MAX_VAL=9 instance). Table-driven vectors plus hand sequences for reset and wrap.
module tb_counter4;
    import counter4_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    counter4_if #(.WIDTH(4)) if_a ();
    counter4_if #(.WIDTH(4)) if_b ();

    counter4 #(.WIDTH(4)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_a.slave)
    );

    counter4 #(.WIDTH(4), .MAX_VAL(32'd9)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_b.slave)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [3:0] exp_q[$];
    logic [3:0] exp9_q[$];

    count_t m_a;
    count_t m_b;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: unsigned modulo (max+1) increment.
    function automatic count_t model_next(input count_t cur, input int max_v, input logic en);
        int v;
        if (!en) return cur;
        v = (int'(cur) + 1) % (max_v + 1);
        return count_t'(v);
    endfunction

    // ---------------- driver ----------------
    // Called on a falling edge; drives enables 2 ns later, checks tc before the
    // rising edge, then checks the new counts 1 ns after it.
    task automatic drive_cycle(input logic en_a, input logic en_b,
                               input logic [3:0] exp_a, input logic [3:0] exp_b,
                               input logic tc_a, input logic tc_b);
        exp_q.push_back(exp_a);
        exp9_q.push_back(exp_b);
        #2;
        if_a.en = en_a;
        if_b.en = en_b;
        #1;
`ifdef COUNTER4_TC_EN
        check("tc_a", 32'(if_a.tc_out), 32'(tc_a));
        check("tc_b", 32'(if_b.tc_out), 32'(tc_b));
`else
        if (tc_a === 1'bx || tc_b === 1'bx) $display("note: unknown tc expectation");
`endif
        @(posedge clk);
        #1;
        check("count_a", 32'(if_a.count_out), 32'(exp_q.pop_front()));
        check("count_b", 32'(if_b.count_out), 32'(exp9_q.pop_front()));
        @(negedge clk);
    endtask

    // Called on a falling edge: asserts reset off-edge with en high on both
    // counters, checks the immediate clear and that reset beats en at the next
    // rising edge, then releases between edges with en low.
    task automatic async_reset();
        #3;
        if_a.en = 1'b1;
        if_b.en = 1'b1;
        rst_n   = 1'b0;
        #1;
        check("rst_async_a", 32'(if_a.count_out), 32'd0);
        check("rst_async_b", 32'(if_b.count_out), 32'd0);
`ifdef COUNTER4_TC_EN
        check("rst_tc_a", 32'(if_a.tc_out), 32'd0);
`endif
        @(posedge clk);
        #1;
        check("rst_wins_a", 32'(if_a.count_out), 32'd0);
        check("rst_wins_b", 32'(if_b.count_out), 32'd0);
        #1;
        if_a.en = 1'b0;
        if_b.en = 1'b0;
        rst_n   = 1'b1;
        m_a = '0;
        m_b = '0;
        @(negedge clk);
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic       en;
        logic [3:0] exp_cnt;
        logic       exp_tc;
    } vec_t;

    vec_t vecs[14];

    // ---------------- watchdog ----------------
    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
        $fatal(1, "timeout");
    end

    // ---------------- main test ----------------
    initial begin
        // 10 enabled edges from 0 count 1..A, then four held edges at A.
        for (int i = 0; i < 10; i++) begin
            vecs[i].en      = 1'b1;
            vecs[i].exp_cnt = 4'(i + 1);
            vecs[i].exp_tc  = 1'b0;
        end
        for (int i = 10; i < 14; i++) begin
            vecs[i].en      = 1'b0;
            vecs[i].exp_cnt = 4'hA;
            vecs[i].exp_tc  = 1'b0;
        end

        rst_n   = 1'b0;
        if_a.en = 1'b0;
        if_b.en = 1'b0;
        m_a = '0;
        m_b = '0;

        // Reset hold: zero throughout, including across a rising edge.
        #6;
        check("reset_hold_a0", 32'(if_a.count_out), 32'd0);
        check("reset_hold_b0", 32'(if_b.count_out), 32'd0);
        #5;
        check("reset_hold_a1", 32'(if_a.count_out), 32'd0);
        check("reset_hold_b1", 32'(if_b.count_out), 32'd0);
        #1;
        rst_n = 1'b1;
        @(negedge clk);

        // Table: enabled count then hold.
        for (int i = 0; i < 14; i++) begin
            drive_cycle(vecs[i].en, 1'b0, vecs[i].exp_cnt, 4'd0, vecs[i].exp_tc, 1'b0);
        end
        m_a = 4'hA;

        // Async reset mid-run, then 6 enabled edges.
        async_reset();
        for (int i = 0; i < 6; i++) begin
            count_t e;
            e = model_next(m_a, 15, 1'b1);
            drive_cycle(1'b1, 1'b0, e, m_b, 1'b0, 1'b0);
            m_a = e;
        end
        check("after_reset_six", 32'(if_a.count_out), 32'd6);

        // Wrap: 17 enabled edges from 0 -> 1..F, 0, 1.
        async_reset();
        for (int i = 0; i < 17; i++) begin
            count_t e;
            logic   tc;
            tc = (m_a == 4'hF);
            e  = model_next(m_a, 15, 1'b1);
            drive_cycle(1'b1, 1'b0, e, m_b, tc, 1'b0);
            m_a = e;
        end
        check("wrap_end", 32'(if_a.count_out), 32'd1);

        // MAX_VAL=9 instance: 11 enabled edges -> 1..9, 0, 1; default instance holds.
        for (int i = 0; i < 11; i++) begin
            count_t e;
            logic   tc;
            tc = (m_b == 4'd9);
            e  = model_next(m_b, 9, 1'b1);
            drive_cycle(1'b0, 1'b1, m_a, e, 1'b0, tc);
            m_b = e;
        end
        check("max9_end", 32'(if_b.count_out), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
